// File: rtl/serializer_arbiter_if.sv
// Request/grant and serial-output bundle for serializer_arbiter.
// The master side drives requests; the slave side (the arbiter) drives the frame outputs.
interface serializer_arbiter_if #(
    parameter int unsigned MSG_SIZE = 64,
    parameter int unsigned NUM_REQ  = 4
);
    localparam int unsigned ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic                          ena;
    logic [NUM_REQ-1:0]            iReq;
    logic [NUM_REQ*MSG_SIZE-1:0]   iData_in;
    logic [NUM_REQ-1:0]            oGrant;
    logic [ID_W-1:0]               oSrc_id;
    logic                          oData_out;
    logic                          oData_flag;
    logic                          oBusy;
    logic                          oDone;

    modport master (
        output ena, iReq, iData_in,
        input  oGrant, oSrc_id, oData_out, oData_flag, oBusy, oDone
    );

    modport slave (
        input  ena, iReq, iData_in,
        output oGrant, oSrc_id, oData_out, oData_flag, oBusy, oDone
    );
endinterface

// File: rtl/serializer_arbiter.sv
// Round-robin arbiter that captures the winning requester's word and shifts it out MSB first,
// followed by a one-cycle gap carrying the done pulse.
module serializer_arbiter #(
    parameter int unsigned MSG_SIZE = 64,
    parameter int unsigned NUM_REQ  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    serializer_arbiter_if.slave   io_bus
);
    localparam int unsigned ID_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned CNT_W = $clog2(MSG_SIZE) + 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(MSG_SIZE - 1);
    localparam logic [ID_W-1:0]  LAST_ID  = ID_W'(NUM_REQ - 1);

    typedef enum logic [1:0] {StIdle, StShift, StGap} state_e;

    state_e               r_state;
    logic [MSG_SIZE-1:0]  r_shift;
    logic [CNT_W-1:0]     r_cnt;
    logic [ID_W-1:0]      r_last;
    logic [ID_W-1:0]      r_src_id;
    logic [NUM_REQ-1:0]   r_grant;
    logic                 r_data_out;
    logic                 r_data_flag;
    logic                 r_busy;
    logic                 r_done;

    logic                 w_found;
    logic [ID_W-1:0]      w_win_id;
    logic [NUM_REQ-1:0]   w_win_oh;
    logic [MSG_SIZE-1:0]  w_win_word;

    // Search starts one past the last winner and wraps, so the last winner has lowest priority.
    always_comb begin
        int unsigned idx;
        idx      = 0;
        w_found  = 1'b0;
        w_win_id = '0;
        for (int unsigned i = 1; i <= NUM_REQ; i++) begin
            idx = (32'(r_last) + i) % NUM_REQ;
            if (!w_found && io_bus.iReq[ID_W'(idx)]) begin
                w_found  = 1'b1;
                w_win_id = ID_W'(idx);
            end
        end
        w_win_oh           = '0;
        w_win_oh[w_win_id] = 1'b1;
        w_win_word         = io_bus.iData_in[32'(w_win_id)*MSG_SIZE +: MSG_SIZE];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= StIdle;
            r_shift     <= '0;
            r_cnt       <= '0;
            r_last      <= LAST_ID;
            r_src_id    <= '0;
            r_grant     <= '0;
            r_data_out  <= 1'b0;
            r_data_flag <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            // Pulses default low; a disabled cycle therefore never produces one.
            r_grant     <= '0;
            r_done      <= 1'b0;
            r_data_flag <= 1'b0;
            if (io_bus.ena) begin
                unique case (r_state)
                    StIdle: begin
                        if (w_found) begin
                            r_shift    <= w_win_word;
                            r_grant    <= w_win_oh;
                            r_src_id   <= w_win_id;
                            r_last     <= w_win_id;
                            r_busy     <= 1'b1;
                            r_cnt      <= '0;
                            r_data_out <= 1'b0;
                            r_state    <= StShift;
                        end
                    end
                    StShift: begin
                        r_data_out  <= r_shift[MSG_SIZE-1];
                        r_data_flag <= 1'b1;
                        r_shift     <= {r_shift[MSG_SIZE-2:0], 1'b0};
                        r_cnt       <= r_cnt + CNT_W'(1);
                        if (r_cnt == LAST_BIT) begin
                            r_state <= StGap;
                        end
                    end
                    StGap: begin
                        r_data_out <= 1'b0;
                        r_done     <= 1'b1;
                        r_busy     <= 1'b0;
                        r_state    <= StIdle;
                    end
                    default: r_state <= StIdle;
                endcase
            end
        end
    end

    assign io_bus.oGrant     = r_grant;
    assign io_bus.oSrc_id    = r_src_id;
    assign io_bus.oData_out  = r_data_out;
    assign io_bus.oData_flag = r_data_flag;
    assign io_bus.oBusy      = r_busy;
    assign io_bus.oDone      = r_done;
endmodule
